// File: rtl/servo_speed_gen_pkg.sv
// servo_pkg: speed codes and the code-to-run-frames mapping for servo_speed_gen
package servo_pkg;
  typedef enum logic [1:0] {SPD_STOP, SPD_SLOW, SPD_MED, SPD_FAST} spd_e;
  function automatic int run_frames(input logic [1:0] code, input int window);
    return code == SPD_FAST ? window : code == SPD_MED ? window / 2 : code == SPD_SLOW ? window / 4 : 0;
  endfunction
endpackage

// File: rtl/servo_speed_gen_pwm_ch.sv
// servo_pwm_ch: one channel's width selection and registered servo pulse
module servo_pwm_ch
  import servo_pkg::*;
#(
  parameter int CW      = 20,
  parameter int FW      = 3,
  parameter int W_STOP  = 75_000,
  parameter int W_CW    = 100_000,
  parameter int W_CCW   = 50_000,
  parameter int WINDOW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_dir,
  input  logic [1:0]    i_sel,
  input  logic [FW-1:0] i_fidx,
  input  logic [CW-1:0] i_cnt_nxt,
  output logic          o_servo
);
  int          w_run;
  logic [CW-1:0] w_width;
  assign w_run   = run_frames(i_sel, WINDOW);
  assign w_width = !i_en ? '0 : (32'(i_fidx) < w_run) ? (i_dir ? CW'(W_CW) : CW'(W_CCW)) : CW'(W_STOP);
  // pulse is high while the upcoming count is below the frame's width
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_servo <= 1'b0;
    else        o_servo <= i_cnt_nxt < w_width;
endmodule

// File: rtl/servo_speed_gen.sv
// servo_speed_gen: multi-channel servo PWM with windowed speed emulation
module servo_speed_gen
  import servo_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int PERIOD_CYC = 1_000_000,
  parameter int W_STOP     = 75_000,
  parameter int W_CW       = 100_000,
  parameter int W_CCW      = 50_000,
  parameter int WINDOW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   en,
  input  logic [N_CH-1:0]   dir,
  input  logic [2*N_CH-1:0] sel,
  output logic [N_CH-1:0]   servo,
  output logic              frame_tick
);
  localparam int CW = $clog2(PERIOD_CYC);
  localparam int FW = $clog2(WINDOW);
  if (W_STOP <= 0 || W_CW <= 0 || W_CCW <= 0 || W_STOP >= PERIOD_CYC || W_CW >= PERIOD_CYC || W_CCW >= PERIOD_CYC) begin : g_bad_width
    $fatal(1, "servo_speed_gen: pulse widths must be in 1..PERIOD_CYC-1");
  end
  if (WINDOW < 8 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
    $fatal(1, "servo_speed_gen: WINDOW must be a power of two >= 8");
  end
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [FW-1:0]     r_fidx, w_fidx_nxt;
  logic [N_CH-1:0]   r_en, r_dir, w_en_nxt, w_dir_nxt;
  logic [2*N_CH-1:0] r_sel, w_sel_nxt;
  logic              w_wrap;
  assign w_wrap     = r_cnt == CW'(PERIOD_CYC - 1);
  assign w_cnt_nxt  = w_wrap ? '0 : r_cnt + CW'(1);
  assign w_fidx_nxt = w_wrap ? r_fidx + FW'(1) : r_fidx;
  assign w_en_nxt   = w_wrap ? en : r_en;
  assign w_dir_nxt  = w_wrap ? dir : r_dir;
  assign w_sel_nxt  = w_wrap ? sel : r_sel;
  // frame counter, window index, frame-boundary input latch and frame strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt      <= '0;
      r_fidx     <= '0;
      r_en       <= '0;
      r_dir      <= '0;
      r_sel      <= '0;
      frame_tick <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_fidx     <= w_fidx_nxt;
      r_en       <= w_en_nxt;
      r_dir      <= w_dir_nxt;
      r_sel      <= w_sel_nxt;
      frame_tick <= w_wrap;
    end
  // channels see next-cycle state so the new frame's width applies from cnt = 0
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    servo_pwm_ch #(
      .CW(CW), .FW(FW), .W_STOP(W_STOP), .W_CW(W_CW), .W_CCW(W_CCW), .WINDOW(WINDOW)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (w_en_nxt[g]),
      .i_dir    (w_dir_nxt[g]),
      .i_sel    (w_sel_nxt[2*g +: 2]),
      .i_fidx   (w_fidx_nxt),
      .i_cnt_nxt(w_cnt_nxt),
      .o_servo  (servo[g])
    );
  end
endmodule

// File: tb/tb_servo_speed_gen.sv
// tb_servo_speed_gen: randomized and directed checks against a frame-arithmetic reference model
module tb_servo_speed_gen;
  localparam int PER = 100, WS = 15, WC = 20, WCC = 10, WIN = 8, NC = 2;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NC-1:0] en = '0, dir = '0;
  logic [2*NC-1:0] sel = '0;
  logic [NC-1:0] servo;
  logic          frame_tick;
  int            n_chk = 0, n_fail = 0;
  int            m_t;
  logic [NC-1:0] m_en, m_dir;
  logic [2*NC-1:0] m_sel;

  servo_speed_gen #(
    .N_CH(NC), .PERIOD_CYC(PER), .W_STOP(WS), .W_CW(WC), .W_CCW(WCC), .WINDOW(WIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .sel(sel), .servo(servo), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // reference: elapsed cycles since reset plus the settings captured at each frame end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_t <= 0;
      m_en <= '0;
      m_dir <= '0;
      m_sel <= '0;
    end else begin
      if (m_t % PER == PER - 1) begin
        m_en <= en;
        m_dir <= dir;
        m_sel <= sel;
      end
      m_t <= m_t + 1;
    end

  function automatic logic [NC-1:0] exp_servo();
    logic [NC-1:0] e;
    int c = m_t % PER;
    int fi = (m_t / PER) % WIN;
    for (int i = 0; i < NC; i++) begin
      int s = int'(m_sel[2*i +: 2]);
      int run = (s == 0) ? 0 : (WIN >> (3 - s));
      int w = !m_en[i] ? 0 : (fi < run) ? (m_dir[i] ? WC : WCC) : WS;
      e[i] = c < w;
    end
    return e;
  endfunction

  function automatic logic exp_tick();
    return (m_t % PER == 0) && (m_t >= PER);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (servo !== '0) begin n_fail++; $display("FAIL reset_servo: got %b want 00", servo); end
    n_chk++;
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    rst_n = 1'b1;
  endtask

  task automatic test_stop();
    en = 2'b11; dir = 2'b00; sel = 4'h0;
    repeat (300) begin
      @(negedge clk);
      n_chk++;
      if (servo !== exp_servo() || frame_tick !== exp_tick()) begin
        n_fail++; $display("FAIL stop t=%0d: servo=%b tick=%b want servo=%b tick=%b", m_t, servo, frame_tick, exp_servo(), exp_tick());
      end
    end
  endtask

  task automatic test_window_med();
    en = 2'b11; dir = 2'b01; sel = 4'b0010;
    repeat (1000) begin
      @(negedge clk);
      n_chk++;
      if (servo !== exp_servo() || frame_tick !== exp_tick()) begin
        n_fail++; $display("FAIL window_med t=%0d: servo=%b tick=%b want servo=%b tick=%b", m_t, servo, frame_tick, exp_servo(), exp_tick());
      end
    end
  endtask

  task automatic test_mixed();
    en = 2'b11; dir = 2'b01; sel = 4'b0111;
    repeat (1000) begin
      @(negedge clk);
      n_chk++;
      if (servo !== exp_servo() || frame_tick !== exp_tick()) begin
        n_fail++; $display("FAIL mixed t=%0d: servo=%b tick=%b want servo=%b tick=%b", m_t, servo, frame_tick, exp_servo(), exp_tick());
      end
    end
  endtask

  task automatic test_dir_toggle();
    int k = 0;
    while (m_t % PER != 50 && k < 2 * PER) begin @(negedge clk); k++; end
    n_chk++;
    if (m_t % PER != 50) begin n_fail++; $display("FAIL dir_wait: pos %0d want 50", m_t % PER); end
    dir[0] = ~dir[0];
    repeat (250) begin
      @(negedge clk);
      n_chk++;
      if (servo !== exp_servo() || frame_tick !== exp_tick()) begin
        n_fail++; $display("FAIL dir_toggle t=%0d: servo=%b tick=%b want servo=%b tick=%b", m_t, servo, frame_tick, exp_servo(), exp_tick());
      end
    end
  endtask

  task automatic test_disable();
    @(negedge clk);
    en[1] = 1'b0;
    repeat (250) begin
      @(negedge clk);
      n_chk++;
      if (servo !== exp_servo() || frame_tick !== exp_tick()) begin
        n_fail++; $display("FAIL disable t=%0d: servo=%b tick=%b want servo=%b tick=%b", m_t, servo, frame_tick, exp_servo(), exp_tick());
      end
      if (m_t >= 300 && m_t % PER >= 1 && m_t % PER < 200) begin
        n_chk++;
        if (servo[1] !== 1'b0 && m_en[1] === 1'b0) begin n_fail++; $display("FAIL disable_ch1 t=%0d: got %b want 0", m_t, servo[1]); end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      en = NC'($urandom); dir = NC'($urandom); sel = (2*NC)'($urandom);
      repeat ($urandom_range(20, 260)) begin
        @(negedge clk);
        n_chk++;
        if (servo !== exp_servo() || frame_tick !== exp_tick()) begin
          n_fail++; $display("FAIL random t=%0d: servo=%b tick=%b want servo=%b tick=%b", m_t, servo, frame_tick, exp_servo(), exp_tick());
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    en = 2'b11; dir = 2'b11; sel = 4'hF;
    while (m_t % PER != PER - 1 && k < 2 * PER) begin @(negedge clk); k++; end
    @(negedge clk);
    while (m_t % PER != 5 && k < 4 * PER) begin @(negedge clk); k++; end
    n_chk++;
    if (servo !== 2'b11) begin n_fail++; $display("FAIL mid_pre: servo=%b want 11", servo); end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (servo !== 2'b00) begin n_fail++; $display("FAIL mid_async: servo=%b want 00", servo); end
    n_chk++;
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL mid_tick: got %b want 0", frame_tick); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (250) begin
      @(negedge clk);
      n_chk++;
      if (servo !== exp_servo() || frame_tick !== exp_tick()) begin
        n_fail++; $display("FAIL after_reset t=%0d: servo=%b tick=%b want servo=%b tick=%b", m_t, servo, frame_tick, exp_servo(), exp_tick());
      end
      if (m_t < PER) begin
        n_chk++;
        if (servo !== 2'b00 || frame_tick !== 1'b0) begin n_fail++; $display("FAIL first_frame t=%0d: servo=%b tick=%b want 00 0", m_t, servo, frame_tick); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stop();
    test_window_med();
    test_mixed();
    test_dir_toggle();
    test_disable();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/servo_speed_gen.md
# servo_speed_gen

Multi-channel hobby-servo pulse generator that emulates speed levels by alternating drive frames with neutral (stop) frames inside a fixed window of PWM frames. It generalises the single-channel fixed-speed test generator: channel count, frame period, pulse widths and window length are parameters, and speed, direction and enable are runtime inputs per channel. It sits between the board-level speed/direction controls and the servo signal pins on the motor test platform.

## Interface
- N_CH, 2, number of independent servo channels
- PERIOD_CYC, 1_000_000, PWM frame length in clk cycles (20 ms at 50 MHz)
- W_STOP, 75_000, neutral pulse width in cycles (1.5 ms)
- W_CW, 100_000, clockwise drive pulse width in cycles (2.0 ms)
- W_CCW, 50_000, counter-clockwise drive pulse width in cycles (1.0 ms)
- WINDOW, 8, frames per speed window; power of two, ≥ 8
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  N_CH  per-channel enable; 0 = no pulses at all
- dir  input  N_CH  per-channel direction; 1 = CW, 0 = CCW
- sel  input  2*N_CH  per-channel speed code, channel i at bits [2i+1:2i]
- servo  output  N_CH  servo control pulses
- frame_tick  output  1  one-cycle strobe at the start of each frame

## Operation
- Shared frame counter cnt, 0..PERIOD_CYC-1, increments every cycle, wraps to 0. Width $clog2(PERIOD_CYC).
- Shared frame index fidx, 0..WINDOW-1, increments on each cnt wrap, wraps to 0.
- en/dir/sel for all channels are latched only on the edge where cnt wraps (PERIOD_CYC-1 → 0); changes mid-frame have no effect until then. No input synchronisers in this block; inputs are assumed synchronous to clk.
- Speed code → run frames per window: 0 → 0, 1 → WINDOW/4, 2 → WINDOW/2, 3 → WINDOW.
- Per-channel pulse width for the frame: latched en = 0 → 0 (output stays low); fidx < run_frames → W_CW if dir else W_CCW; otherwise → W_STOP.
- servo[i] is high exactly during cycles with cnt < width_i; width 0 gives a flat low frame.
- fidx is not reset on sel/dir/en changes; a speed change takes effect at the current window position.
- Elaboration check: W_STOP, W_CW, W_CCW all < PERIOD_CYC and > 0; fatal otherwise.

## Timing
- Reset (async assert, released synchronously to clk by board logic): cnt = 0, fidx = 0, latched en = 0, dir = 0, sel = 0; servo = 0, frame_tick = 0.
- First frame after reset always outputs low on all channels (latched en = 0); first latch occurs at the end of that frame.
- servo is registered but computed from the next-cycle cnt, so it is high exactly for the cycles where cnt ∈ [0, width-1]; no extra latency.
- frame_tick is registered, high for the single cycle where cnt == 0, from the second frame onward; never high in the first frame after reset.
- Input-to-output latency: a change sampled at wrap W appears from cnt = 0 of the frame starting at W (at most PERIOD_CYC cycles after the input changes).
- Reset mid-frame: servo drops low immediately (async), all state returns to reset values.

## Structure
- Package servo_pkg: speed-code constants (SPD_STOP, SPD_SLOW, SPD_MED, SPD_FAST) and function run_frames(code, window).
- Top level holds cnt, fidx, frame_tick and the latch registers.
- Sub-module servo_pwm_ch (one instance per channel via generate): takes latched en/dir/sel, fidx, next cnt; produces width select and the registered servo bit.

## Test plan
Use PERIOD_CYC=100, W_STOP=15, W_CW=20, W_CCW=10, WINDOW=8, N_CH=2.
- Reset, then en=2'b11, sel=0 → frame 1: servo all low; from frame 2: both channels give 15-cycle pulses every 100 cycles; frame_tick every 100 cycles starting at cycle 100.
- ch0 en=1, dir=1, sel=2 → per window: 4 frames with 20-cycle pulses, then 4 frames with 15-cycle pulses, repeating.
- ch1 en=1, dir=0, sel=1 → 2 frames of 10-cycle pulses, 6 frames of 15-cycle pulses per window; ch0 sel=3 concurrently → 20-cycle pulses every frame.
- Toggle ch0 dir at cnt=50 → current frame unchanged; new width from next frame start.
- en=0 on ch1 → ch1 flat low from next frame; ch0 unaffected.
- Assert rst_n=0 at cnt=5 during a pulse → servo goes low immediately; after release, one all-low frame, no frame_tick until cycle 100.
